// File: rtl/grf_multiport_bypass_pkg.sv
// Shared types and constants for the general register file.
package grf_multiport_bypass_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } grf_state_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/grf_multiport_bypass_read_port.sv
// One register-file read port: storage mux plus same-cycle write forwarding.
module grf_multiport_bypass_read_port
  import grf_multiport_bypass_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                 ra,
  input  logic [ADDR_W-1:0]                 wa,
  input  logic [DATA_W-1:0]                 wd,
  input  logic                              byp_en,
  input  logic [(2**ADDR_W)*DATA_W-1:0]     rf_flat,
  output logic [DATA_W-1:0]                 rd
);

  always_comb begin
    rd = rf_flat[32'(ra)*DATA_W +: DATA_W];
    if (ra == ADDR_W'(ZERO_REG)) begin
      rd = '0;
    end else if ((BYPASS != 0) && byp_en && (ra == wa)) begin
      rd = wd;
    end
  end

endmodule

// File: rtl/grf_multiport_bypass.sv
// Decode-stage register file: NUM_RD read ports, one write port, $0 hardwired,
// soft-clear sequencer and registered write trace.
module grf_multiport_bypass
  import grf_multiport_bypass_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                pc_i,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [ADDR_W-1:0]          trace_addr,
  output logic [DATA_W-1:0]          trace_data
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       rf [1:DEPTH-1];
  logic [DEPTH*DATA_W-1:0] rf_flat;
  grf_state_e              state, state_nxt;
  logic [ADDR_W-1:0]       cnt, cnt_nxt;
  logic                    commit;

  assign clr_busy = (state == ST_CLEAR);
  assign commit   = we && !clr_busy && (wa != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter wraps to 0 on the last clear cycle; that wrap is the exit, not a write to $0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (state == ST_CLEAR) begin
      rf[cnt] <= '0;
    end else if (commit) begin
      rf[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc   <= pc_i;
        trace_addr <= wa;
        trace_data <= wd;
      end
    end
  end

  always_comb begin
    rf_flat = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      rf_flat[i*DATA_W +: DATA_W] = rf[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    grf_multiport_bypass_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .ra      (ra[k*ADDR_W +: ADDR_W]),
      .wa      (wa),
      .wd      (wd),
      .byp_en  (commit),
      .rf_flat (rf_flat),
      .rd      (rd[k*DATA_W +: DATA_W])
    );
  end

endmodule
